// File: rtl/serial_rx.sv
// serial_rx: MSB-first serial word receiver framed by data_enable.
// Emits data_valid on a full frame, frame_error on a short frame.
module serial_rx #(
    parameter int WIDTH = 32
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             data_enable,
    input  logic             sdi,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_error,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    // Next-state: frame start, bit accumulation, completion and abort.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_enable) begin
                    shift_d   = SW'({shift_q, sdi});
                    bit_cnt_d = CW'(1);
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (!data_enable) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = IDLE;
                end else if (bit_cnt_q == LAST) begin
                    data_d    = {shift_q, sdi};
                    valid_d   = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = IDLE;
                end else begin
                    shift_d   = SW'({shift_q, sdi});
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; reset clears everything at once.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = err_q;
    assign busy        = (state_q == RECV);
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: random frames against a bit-queue receiver model,
// plus literal expectations for the directed scenarios.
module tb_serial_rx;

    localparam int W = 32;

    logic         sclk = 1'b0;
    logic         reset = 1'b0;
    logic         data_enable = 1'b0;
    logic         sdi = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_error;
    logic         busy;
    logic [7:0]   frame_cnt;

    serial_rx #(.WIDTH(W)) dut (
        .sclk        (sclk),
        .reset       (reset),
        .data_enable (data_enable),
        .sdi         (sdi),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid = 0;
    int prev_valid = 0;

    bit           bits[$];
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_err;
    int           exp_cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        bits.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic model_step(input logic de, input logic b);
        if (de) begin
            exp_err = 1'b0;
            bits.push_back(b);
            if (bits.size() == W) begin
                exp_data = '0;
                foreach (bits[i]) exp_data = (exp_data << 1) | W'(bits[i]);
                exp_valid = 1'b1;
                exp_cnt   = (exp_cnt + 1) % 256;
                bits.delete();
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
            exp_err   = (bits.size() != 0);
            bits.delete();
        end
    endtask

    task automatic compare_all();
        check("data_out", data_out, exp_data);
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("frame_error", 32'(frame_error), 32'(exp_err));
        check("busy", 32'(busy), 32'(bits.size() != 0));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("pulse_excl", 32'(data_valid & frame_error), 32'd0);
        if (data_valid === 1'b1) begin
            prev_valid = last_valid;
            last_valid = cyc;
        end
    endtask

    task automatic tick(input logic de, input logic b);
        @(negedge sclk);
        data_enable = de;
        sdi = b;
        @(posedge sclk);
        cyc++;
        if (reset) model_clear();
        else model_step(de, b);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) tick(1'b1, w[i]);
    endtask

    task automatic pin_zero(input string tag);
        check({tag, "_data"}, data_out, 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_err"}, 32'(frame_error), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    logic [W-1:0] w;

    initial begin
        model_clear();
        #1 reset = 1'b1;
        #1 pin_zero("rst_init");
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        #2 reset = 1'b0;

        // enable low: sdi must be ignored
        for (int i = 0; i < 10; i++) tick(1'b0, 1'(i));
        pin_zero("idle_toggle");

        // single frame
        send_word(32'hA5C3_0F81);
        check("f1_data", data_out, 32'hA5C3_0F81);
        check("f1_valid", 32'(data_valid), 32'd1);
        check("f1_cnt", 32'(frame_cnt), 32'd1);
        tick(1'b0, 1'b0);
        check("f1_valid_drop", 32'(data_valid), 32'd0);
        check("f1_busy_after", 32'(busy), 32'd0);

        // back-to-back frames
        send_word(32'hFFFF_0000);
        check("b2b_d0", data_out, 32'hFFFF_0000);
        send_word(32'h0000_FFFF);
        check("b2b_d1", data_out, 32'h0000_FFFF);
        check("b2b_gap", 32'(last_valid - prev_valid), 32'd32);
        check("b2b_cnt", 32'(frame_cnt), 32'd3);
        tick(1'b0, 1'b0);

        // short frame
        send_word(32'h1234_5678);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'($urandom_range(0, 1)));
        check("short_busy", 32'(busy), 32'd1);
        tick(1'b0, 1'b1);
        check("short_err", 32'(frame_error), 32'd1);
        check("short_data", data_out, 32'h1234_5678);
        check("short_cnt", 32'(frame_cnt), 32'd4);
        tick(1'b0, 1'b0);
        check("short_err_drop", 32'(frame_error), 32'd0);

        // async reset mid-frame
        w = 32'hCAFE_F00D;
        for (int i = W - 1; i >= 16; i--) tick(1'b1, w[i]);
        @(negedge sclk);
        #2 reset = 1'b1;
        #1 pin_zero("rst_mid");
        model_clear();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        #2 reset = 1'b0;
        tick(1'b0, 1'b0);
        send_word(32'hDEAD_BEEF);
        check("post_rst_data", data_out, 32'hDEAD_BEEF);
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // random traffic up to the counter wrap
        for (int f = 0; f < 255; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                int n;
                n = $urandom_range(1, W - 1);
                for (int i = 0; i < n; i++)
                    tick(1'b1, 1'($urandom_range(0, 1)));
                tick(1'b0, 1'b0);
            end
            send_word(W'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--)
                tick(1'b0, 1'($urandom_range(0, 1)));
        end
        check("wrap_cnt", 32'(frame_cnt), 32'd0);
        send_word(32'h0BAD_CAFE);
        check("wrap_next", 32'(frame_cnt), 32'd1);
        tick(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
